// File: rtl/pov_texture_mapper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pov_pkg : shared encodings and timing defaults for the POV texture mapper |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pov_pkg;

  localparam int CLK_FREQ    = 100_000_000;
  localparam int DEFAULT_FPS = 24;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  localparam logic [0:0] ST_PLAY = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pov_texture_mapper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pov_texture_mapper_if : angle/pixel request, playback control, ROM addr  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pov_texture_mapper_if #(
  parameter int THETA_BITS     = 6,
  parameter int PX_BITS        = 6,
  parameter int ADDR_BITS      = 19,
  parameter int FRAME_IDX_BITS = 6
);

  logic [THETA_BITS-1:0]     theta;
  logic [PX_BITS-1:0]        px_num;
  logic [THETA_BITS-1:0]     theta_offset;
  logic [31:0]               cycles_per_frame;
  logic [FRAME_IDX_BITS-1:0] clip_start;
  logic [FRAME_IDX_BITS-1:0] clip_len;
  logic [1:0]                mode;
  logic                      play;
  logic                      step;
  logic                      restart;
  logic [ADDR_BITS-1:0]      rom_addr;
  logic                      addr_valid;
  logic [FRAME_IDX_BITS-1:0] frame_idx;
  logic                      frame_tick;
  logic                      done;

  modport master (
    output theta, px_num, theta_offset, cycles_per_frame, clip_start, clip_len,
           mode, play, step, restart,
    input  rom_addr, addr_valid, frame_idx, frame_tick, done
  );

  modport slave (
    input  theta, px_num, theta_offset, cycles_per_frame, clip_start, clip_len,
           mode, play, step, restart,
    output rom_addr, addr_valid, frame_idx, frame_tick, done
  );

endinterface
`default_nettype wire

// File: rtl/pov_texture_mapper_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pov_frame_sequencer : frame timer, clip config latch, play/done FSM      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pov_frame_sequencer
  import pov_pkg::*;
#(
  parameter int          NUM_FRAMES     = 24,
  parameter int          FRAME_IDX_BITS = $clog2(NUM_FRAMES) + 1,
  parameter logic [31:0] CPF_DEFAULT    = 32'(CLK_FREQ / DEFAULT_FPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_play,
  input  logic                      i_step,
  input  logic                      i_restart,
  input  logic [31:0]               i_cycles_per_frame,
  input  logic [FRAME_IDX_BITS-1:0] i_clip_start,
  input  logic [FRAME_IDX_BITS-1:0] i_clip_len,
  input  logic [1:0]                i_mode,
  output logic [FRAME_IDX_BITS-1:0] o_frame_idx,
  output logic [FRAME_IDX_BITS-1:0] o_clip_start,
  output logic                      o_frame_tick,
  output logic                      o_done
);

  localparam logic [FRAME_IDX_BITS-1:0] c_NF  = FRAME_IDX_BITS'(NUM_FRAMES);
  localparam logic [FRAME_IDX_BITS-1:0] c_ONE = FRAME_IDX_BITS'(1);

  logic [31:0]               r_cpf;
  logic [FRAME_IDX_BITS-1:0] r_clip_start;
  logic [FRAME_IDX_BITS-1:0] r_clip_len;
  logic [1:0]                r_mode;
  logic [31:0]               r_timer;
  logic                      r_dir;
  logic [0:0]                r_state;
  logic [FRAME_IDX_BITS-1:0] r_frame_idx;
  logic                      r_chg;
  logic                      r_frame_tick;

  logic [31:0]               w_cpf_s;
  logic [FRAME_IDX_BITS-1:0] w_start_s;
  logic [FRAME_IDX_BITS-1:0] w_len_s;
  logic                      w_run;
  logic                      w_wrap;
  logic                      w_adv;
  logic                      w_last;
  logic                      w_hit_end;
  logic [FRAME_IDX_BITS-1:0] w_idx_nx;
  logic                      w_dir_nx;
  logic [0:0]                w_state_nx;
  logic                      w_done;

  assign w_cpf_s   = (i_cycles_per_frame == 32'd0) ? 32'd1 : i_cycles_per_frame;
  assign w_start_s = (i_clip_start >= c_NF) ? '0 : i_clip_start;
  assign w_len_s   = (i_clip_len == '0) ? c_ONE : ((i_clip_len > c_NF) ? c_NF : i_clip_len);

  assign w_run  = (r_state == ST_PLAY) && i_play;
  assign w_wrap = w_run && (r_timer == r_cpf - 32'd1);
  assign w_adv  = (r_state == ST_PLAY) && (w_wrap || (i_step && !i_play));
  assign w_last = (r_frame_idx >= r_clip_len - c_ONE);

  // r_dir: 0 = forward, 1 = backward (ping-pong only)
  always_comb begin
    w_idx_nx = r_frame_idx;
    w_dir_nx = r_dir;
    case (r_mode)
      MODE_PINGPONG: begin
        if (r_clip_len != c_ONE) begin
          if (!r_dir) begin
            if (w_last) begin
              w_idx_nx = r_frame_idx - c_ONE;
              w_dir_nx = 1'b1;
            end else begin
              w_idx_nx = r_frame_idx + c_ONE;
            end
          end else if (r_frame_idx == '0) begin
            w_idx_nx = c_ONE;
            w_dir_nx = 1'b0;
          end else begin
            w_idx_nx = r_frame_idx - c_ONE;
          end
        end
      end
      MODE_ONESHOT: begin
        if (!w_last) w_idx_nx = r_frame_idx + c_ONE;
      end
      default: begin
        w_idx_nx = w_last ? '0 : r_frame_idx + c_ONE;
      end
    endcase
  end

  assign w_hit_end = (r_mode == MODE_ONESHOT) && (w_idx_nx == r_clip_len - c_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PLAY;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_PLAY: if (!i_restart && w_adv && w_hit_end) w_state_nx = ST_DONE;
      ST_DONE: if (i_restart) w_state_nx = ST_PLAY;
      default: w_state_nx = ST_PLAY;
    endcase
  end

  always_comb begin
    w_done = 1'b0;
    if (r_state == ST_DONE) w_done = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpf        <= CPF_DEFAULT;
      r_clip_start <= '0;
      r_clip_len   <= c_NF;
      r_mode       <= MODE_LOOP;
      r_timer      <= 32'd0;
      r_dir        <= 1'b0;
      r_frame_idx  <= '0;
      r_chg        <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      // the tick trails the index change by one cycle
      r_frame_tick <= r_chg;
      if (i_restart) begin
        r_cpf        <= w_cpf_s;
        r_clip_start <= w_start_s;
        r_clip_len   <= w_len_s;
        r_mode       <= i_mode;
        r_timer      <= 32'd0;
        r_dir        <= 1'b0;
        r_frame_idx  <= '0;
        r_chg        <= 1'b0;
      end else begin
        if (w_run) r_timer <= w_wrap ? 32'd0 : r_timer + 32'd1;
        r_chg <= w_adv && (w_idx_nx != r_frame_idx);
        if (w_adv) begin
          r_frame_idx <= w_idx_nx;
          r_dir       <= w_dir_nx;
        end
      end
    end
  end

  assign o_frame_idx  = r_frame_idx;
  assign o_clip_start = r_clip_start;
  assign o_frame_tick = r_frame_tick;
  assign o_done       = w_done;

endmodule
`default_nettype wire

// File: rtl/pov_texture_mapper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pov_texture_mapper : (theta, px, frame) -> texture ROM address, 2 stages |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pov_texture_mapper
  import pov_pkg::*;
#(
  parameter int LED_COUNT      = 52,
  parameter int TEX_WIDTH      = 256,
  parameter int NUM_FRAMES     = 24,
  parameter int THETA_BITS     = 6,
  parameter int PX_BITS        = 6,
  parameter int ADDR_BITS      = $clog2(TEX_WIDTH * LED_COUNT * NUM_FRAMES),
  parameter int FRAME_IDX_BITS = $clog2(NUM_FRAMES) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  pov_texture_mapper_if.slave  bus
);

  localparam int c_COL_BITS  = (TEX_WIDTH > 1) ? $clog2(TEX_WIDTH) : 1;
  localparam int c_PROD_BITS = THETA_BITS + c_COL_BITS + 1;
  localparam logic [FRAME_IDX_BITS:0] c_NF      = (FRAME_IDX_BITS + 1)'(NUM_FRAMES);
  localparam logic [PX_BITS:0]        c_LED_LIM = (PX_BITS + 1)'(LED_COUNT);

  logic [FRAME_IDX_BITS-1:0] w_frame_idx;
  logic [FRAME_IDX_BITS-1:0] w_clip_start;
  logic                      w_frame_tick;
  logic                      w_done;

  logic [THETA_BITS-1:0]     w_ts;
  logic [c_PROD_BITS-1:0]    w_prod;
  logic [c_COL_BITS-1:0]     w_col;
  logic [FRAME_IDX_BITS:0]   w_af_sum;
  logic [FRAME_IDX_BITS:0]   w_af;
  logic                      w_px_ok;
  logic [ADDR_BITS-1:0]      w_addr;

  logic [c_COL_BITS-1:0]     r_s1_col;
  logic [FRAME_IDX_BITS-1:0] r_s1_af;
  logic [PX_BITS-1:0]        r_s1_px;
  logic                      r_s1_ok;
  logic [ADDR_BITS-1:0]      r_rom_addr;
  logic                      r_addr_valid;

  pov_frame_sequencer #(
    .NUM_FRAMES     (NUM_FRAMES),
    .FRAME_IDX_BITS (FRAME_IDX_BITS),
    .CPF_DEFAULT    (32'(CLK_FREQ / DEFAULT_FPS))
  ) u_seq (
    .clk                (clk),
    .rst                (reset),
    .i_play             (bus.play),
    .i_step             (bus.step),
    .i_restart          (bus.restart),
    .i_cycles_per_frame (bus.cycles_per_frame),
    .i_clip_start       (bus.clip_start),
    .i_clip_len         (bus.clip_len),
    .i_mode             (bus.mode),
    .o_frame_idx        (w_frame_idx),
    .o_clip_start       (w_clip_start),
    .o_frame_tick       (w_frame_tick),
    .o_done             (w_done)
  );

  // angle wraps naturally at THETA_BITS; col scales one revolution onto TEX_WIDTH
  assign w_ts     = bus.theta + bus.theta_offset;
  assign w_prod   = c_PROD_BITS'(w_ts) * c_PROD_BITS'(TEX_WIDTH);
  assign w_col    = c_COL_BITS'(w_prod >> THETA_BITS);
  assign w_af_sum = {1'b0, w_clip_start} + {1'b0, w_frame_idx};
  assign w_af     = (w_af_sum >= c_NF) ? w_af_sum - c_NF : w_af_sum;
  assign w_px_ok  = ({1'b0, bus.px_num} < c_LED_LIM);

  assign w_addr = ADDR_BITS'(r_s1_af) * ADDR_BITS'(LED_COUNT * TEX_WIDTH)
                + ADDR_BITS'(r_s1_px) * ADDR_BITS'(TEX_WIDTH)
                + ADDR_BITS'(r_s1_col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_col     <= '0;
      r_s1_af      <= '0;
      r_s1_px      <= '0;
      r_s1_ok      <= 1'b0;
      r_rom_addr   <= '0;
      r_addr_valid <= 1'b0;
    end else begin
      r_s1_col     <= w_col;
      r_s1_af      <= FRAME_IDX_BITS'(w_af);
      r_s1_px      <= bus.px_num;
      r_s1_ok      <= w_px_ok;
      r_addr_valid <= r_s1_ok;
      if (r_s1_ok) r_rom_addr <= w_addr;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.addr_valid = r_addr_valid;
  assign bus.frame_idx  = w_frame_idx;
  assign bus.frame_tick = w_frame_tick;
  assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: doc/pov_texture_mapper.md
Name: pov_texture_mapper

Overview:
- Parametrised successor to the fixed 52-LED / 256-column / 24-frame mapper in the top level.
- Converts beam-derived angle `theta` and the strip's requested LED index into a texture-ROM address.
- Adds runtime-selectable animation clips, frame rate, play/pause/step, loop/ping-pong/one-shot modes, and a rotational phase offset.
- Sits between theta_from_breakbeam / neopixel_controller and the texture ROM; output address is registered.

Parameters:
- LED_COUNT, 52: LEDs per strip (texture rows).
- TEX_WIDTH, 256: texture columns per revolution; any value ≥ 1.
- NUM_FRAMES, 24: frames stored in ROM.
- THETA_BITS, 6: angle index width.
- PX_BITS, 6: LED index width; 2^PX_BITS ≥ LED_COUNT.
- ADDR_BITS, $clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES): ROM address width.
- FRAME_IDX_BITS, $clog2(NUM_FRAMES)+1: frame counter width.

Ports:
- clk, in, 1: system clock (100 MHz).
- reset, in, 1: asynchronous, active-high reset.
- theta, in, THETA_BITS: current angle index.
- px_num, in, PX_BITS: LED index requested by the strip controller.
- theta_offset, in, THETA_BITS: rotational phase added to theta.
- cycles_per_frame, in, 32: clk cycles per animation frame; 0 is treated as 1.
- clip_start, in, FRAME_IDX_BITS: first ROM frame of the clip; a value ≥ NUM_FRAMES is treated as 0.
- clip_len, in, FRAME_IDX_BITS: frames in the clip; 0 is treated as 1; a value > NUM_FRAMES is treated as NUM_FRAMES.
- mode, in, 2: 00 loop, 01 ping-pong, 10 one-shot, 11 behaves as loop.
- play, in, 1: level; 1 = advance on timer, 0 = paused.
- step, in, 1: single-cycle pulse; advance one frame while paused.
- restart, in, 1: single-cycle pulse; latch config and return to frame 0.
- rom_addr, out, ADDR_BITS: texture ROM address.
- addr_valid, out, 1: rom_addr corresponds to an in-range px_num.
- frame_idx, out, FRAME_IDX_BITS: clip-relative frame index.
- frame_tick, out, 1: one-cycle pulse on every frame change.
- done, out, 1: one-shot clip completed; held until restart.

Behaviour:
- Reset values:
  - rom_addr = 0, addr_valid = 0, frame_idx = 0, frame_tick = 0, done = 0.
  - Timer = 0, direction = forward, state = PLAY.
  - Config registers load clip_start 0, clip_len NUM_FRAMES, mode loop, cycles_per_frame CLK/24 (4_166_666).
  - Reset is asynchronous: it takes effect mid-frame and mid-pipeline with no completion of in-flight work.
- Config latch:
  - clip_start, clip_len, mode and cycles_per_frame are sampled only on restart (after sanitising).
  - theta_offset and play take effect live.
- Timer:
  - Counts 0..cpf-1 while state = PLAY and play = 1; holds while paused.
  - At cpf-1 it wraps to 0 and produces an advance event.
- Advance event (timer wrap, or step with play = 0; step while play = 1 is ignored):
  - Loop: frame_idx+1, wrapping clip_len-1 → 0.
  - Ping-pong: moves in the current direction and reverses at the ends (…, L-2, L-1, L-2, …, 1, 0, 1, …). With clip_len = 1 it stays at 0.
  - One-shot: increments. At L-1 the state moves to DONE and done = 1; no further advance and frame_tick stays low.
  - frame_tick pulses the cycle after frame_idx changes. No tick when the index does not change (clip_len = 1).
- FSM:
  - PLAY → DONE as above.
  - DONE → PLAY on restart only.
  - restart has priority over a same-cycle advance: frame_idx = 0, timer = 0, direction = forward, done = 0.
- Address pipeline (2-cycle latency, fully pipelined, one new address per clk):
  - Stage 1 computes `ts = (theta + theta_offset) mod 2^THETA_BITS` and `col = (ts * TEX_WIDTH) >> THETA_BITS`.
  - Stage 1 also computes the absolute frame `af = clip_start + frame_idx`; if af ≥ NUM_FRAMES it becomes af - NUM_FRAMES (single conditional subtract).
  - Stage 1 registers px_num and the in-range flag `px_num < LED_COUNT`.
  - Stage 2 computes `rom_addr = af*LED_COUNT*TEX_WIDTH + px*TEX_WIDTH + col`.
  - Intermediate products use widths sized to avoid overflow; col is always ≤ TEX_WIDTH-1.
- Out-of-range px_num:
  - addr_valid = 0 for that output cycle.
  - rom_addr holds its previous value.

Decomposition:
- Package pov_pkg holds:
  - mode encodings (MODE_LOOP, MODE_PINGPONG, MODE_ONESHOT).
  - FSM state encoding (ST_PLAY, ST_DONE).
  - default CLK_FREQ = 100_000_000 and DEFAULT_FPS = 24.
- Sub-module pov_frame_sequencer holds the timer, config latch, FSM and direction logic, and outputs frame_idx, frame_tick and done.
- pov_texture_mapper instantiates the sequencer and owns the 2-stage address pipeline.

Test Plan:
- Reset, then restart with cpf = 4, len = 3, loop, play = 1 -> frame_idx 0,1,2,0 every 4 cycles, with frame_tick one cycle after each change.
- Ping-pong, len = 4, cpf = 2 -> frame_idx 0,1,2,3,2,1,0,1; len = 1 -> frame_idx constant 0 with no frame_tick.
- One-shot, len = 3 -> done = 1 at frame 2 and holds; a restart coinciding with an advance gives frame_idx = 0 and done = 0 the next cycle.
- play = 0 plus three step pulses -> three advances; step while play = 1 -> no extra advance; mid-frame asynchronous reset -> all outputs 0 immediately.
- Defaults with theta = 63, offset = 2, px = 5, clip_start = 22, frame_idx = 3 -> af = 1, col = 4, rom_addr = 13312+1280+4 = 14596, valid after 2 cycles.
- px_num = 52 -> addr_valid = 0 and rom_addr unchanged. Random theta/px streaming checked against a reference model at 2-cycle latency.
